// File: rtl/reg_preload_ctrl.sv
// reg_preload_ctrl
//   Fills the register file from a valid/ready stream after a start pulse.
//   Words land in x[FIRST_REG]..x[NREG-1], one register per accepted word.
//   An optional read-back pass then adds up the register contents and compares
//   the result with the sum of the streamed words. While loading or verifying,
//   the controller owns the regfile write port and stalls the core.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   start, verify_en           start pulse; verify_en is sampled with start
//   in_valid/in_data/in_ready  input word stream
//   core_write_*               core write port (passed through when idle)
//   rf_write_*                 regfile write port
//   rf_read_reg/rf_read_data   regfile asynchronous read port (used by verify)
//   busy, core_stall           high in LOAD or VERIFY
//   done, check_ok             DONE state flag and checksum result
module reg_preload_ctrl #(
    parameter int XLEN      = 64,
    parameter int NREG      = 32,
    parameter int FIRST_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            verify_en,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_data,
    output logic            in_ready,
    input  logic [4:0]      core_write_reg,
    input  logic [XLEN-1:0] core_write_data,
    input  logic            core_write_en,
    output logic [4:0]      rf_write_reg,
    output logic [XLEN-1:0] rf_write_data,
    output logic            rf_write_en,
    output logic [4:0]      rf_read_reg,
    input  logic [XLEN-1:0] rf_read_data,
    output logic            busy,
    output logic            core_stall,
    output logic            done,
    output logic            check_ok
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(NREG - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t          state, state_nxt;
    logic [4:0]      idx;
    logic [XLEN-1:0] sum_w, sum_r;
    logic            vfy;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (in_valid && idx == LAST) state_nxt = vfy ? VERIFY : DONE;
            VERIFY:     if (idx == LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // index, checksums and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= FIRST;
            sum_w    <= '0;
            sum_r    <= '0;
            check_ok <= 1'b0;
            vfy      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx      <= FIRST;
                        sum_w    <= '0;
                        sum_r    <= '0;
                        check_ok <= 1'b0;
                        vfy      <= verify_en;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        sum_w <= sum_w + in_data;
                        if (idx == LAST) begin
                            idx <= FIRST;
                            // without a verify pass the load is trusted
                            if (!vfy) check_ok <= 1'b1;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                VERIFY: begin
                    sum_r <= sum_r + rf_read_data;
                    if (idx == LAST) begin
                        // include the last register read this cycle
                        check_ok <= ((sum_r + rf_read_data) == sum_w);
                        idx      <= FIRST;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs; the core write port is muxed through only while idle/done
    always_comb begin
        in_ready      = 1'b0;
        rf_write_reg  = core_write_reg;
        rf_write_data = core_write_data;
        rf_write_en   = core_write_en;
        rf_read_reg   = 5'd0;
        case (state)
            LOAD: begin
                in_ready      = 1'b1;
                rf_write_reg  = idx;
                rf_write_data = in_data;
                rf_write_en   = in_valid;
            end
            VERIFY: begin
                rf_write_en = 1'b0;
                rf_read_reg = idx;
            end
            default: ;
        endcase
    end

    assign busy       = (state == LOAD) || (state == VERIFY);
    assign core_stall = busy;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_reg_preload_ctrl.sv
module tb_reg_preload_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, verify_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic [4:0]  core_write_reg = '0;
    logic [63:0] core_write_data = '0;
    logic        core_write_en = 1'b0;
    logic [4:0]  rf_write_reg, rf_read_reg;
    logic [63:0] rf_write_data, rf_read_data;
    logic        rf_write_en, busy, core_stall, done, check_ok;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_preload_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_write_reg(core_write_reg), .core_write_data(core_write_data),
        .core_write_en(core_write_en),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_write_en(rf_write_en), .rf_read_reg(rf_read_reg),
        .rf_read_data(rf_read_data), .busy(busy), .core_stall(core_stall),
        .done(done), .check_ok(check_ok)
    );

    // regfile model: x0 hardwired, cleared by reset, optional x7 corruption
    logic [63:0] rf [32];
    bit          corrupt7 = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (rf_write_en && rf_write_reg != 5'd0) rf[rf_write_reg] <= rf_write_data;
            if (corrupt7) rf[7] <= '0;
        end
    end
    assign rf_read_data = rf[rf_read_reg];

    // scoreboard of expected stream writes
    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
    } wr_t;
    wr_t q[$];

    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (in_ready && in_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty: transfer to x%0d with no expected write", rf_write_reg);
                end else begin
                    e = q.pop_front();
                    if (rf_write_en !== 1'b1 || rf_write_reg !== e.r || rf_write_data !== e.d) begin
                        bad++;
                        $display("FAIL sb_write: got en=%0b x%0d=%h want en=1 x%0d=%h",
                                 rf_write_en, rf_write_reg, rf_write_data, e.r, e.d);
                    end
                end
            end else if (busy) begin
                total++;
                if (rf_write_en !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_write: rf_write_en=%0b x%0d while busy without transfer, want 0",
                             rf_write_en, rf_write_reg);
                end
            end
        end
    end

    function automatic logic [63:0] word(input int k);
        return 64'(k) * 64'h1111;
    endfunction

    // caller is at posedge+1 with the DUT in IDLE or DONE
    task automatic run_load(input bit v, input bit alt, input bit noise, input bit corrupt);
        int n;
        logic [63:0] w;
        corrupt7  = corrupt;
        start     = 1'b1;
        verify_en = v;
        @(posedge clk); #1;
        start     = 1'b0;
        verify_en = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL start: busy=%0b done=%0b want 1 0", busy, done);
        end
        if (noise) begin
            core_write_en   = 1'b1;
            core_write_reg  = 5'd3;
            core_write_data = 64'hDEAD;
            total++;
            if (core_stall !== 1'b1) begin
                bad++;
                $display("FAIL core_stall: got %0b want 1", core_stall);
            end
        end
        for (int k = 1; k <= 31; k++) begin
            in_valid = 1'b1;
            in_data  = word(k);
            q.push_back('{r: 5'(k), d: word(k)});
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL in_ready: word %0d got %0b want 1", k, in_ready);
            end
            @(posedge clk); #1;
            if (alt && k < 31) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid      = 1'b0;
        core_write_en = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_end: in_ready=%0b after last word, want 0", in_ready);
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== (v ? 31 : 0)) begin
            bad++;
            $display("FAIL done_latency: %0d cycles after last word, want %0d", n, v ? 31 : 0);
        end
        total++;
        if (check_ok !== (v ? !corrupt : 1'b1)) begin
            bad++;
            $display("FAIL check_ok: got %0b want %0b", check_ok, v ? !corrupt : 1'b1);
        end
        for (int k = 0; k < 32; k++) begin
            w = (k == 0 || (corrupt && k == 7)) ? 64'd0 : word(k);
            total++;
            if (rf[k] !== w) begin
                bad++;
                $display("FAIL reg_x%0d: got %h want %h", k, rf[k], w);
            end
        end
        corrupt7 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        total++;
        if (done !== 0 || busy !== 0 || in_ready !== 0 || check_ok !== 0 || rf_read_reg !== 0) begin
            bad++;
            $display("FAIL reset: done=%0b busy=%0b in_ready=%0b check_ok=%0b rd=%0d want all 0",
                     done, busy, in_ready, check_ok, rf_read_reg);
        end
        core_write_en   = 1'b1;
        core_write_reg  = 5'd5;
        core_write_data = 64'hAB;
        #1;
        total++;
        if (rf_write_en !== 1'b1 || rf_write_reg !== 5'd5 || rf_write_data !== 64'hAB) begin
            bad++;
            $display("FAIL passthru: en=%0b x%0d=%h want 1 x5=ab", rf_write_en, rf_write_reg, rf_write_data);
        end
        @(posedge clk); #1;
        core_write_en = 1'b0;
        total++;
        if (rf[5] !== 64'hAB) begin
            bad++;
            $display("FAIL passthru_commit: x5=%h want ab", rf[5]);
        end
    endtask

    task automatic test_back_to_back();
        run_load(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        run_load(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_verify();
        run_load(1'b1, 1'b0, 1'b0, 1'b0);
        run_load(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_core_drop();
        run_load(1'b0, 1'b0, 1'b1, 1'b0);
        core_write_en   = 1'b1;
        core_write_reg  = 5'd3;
        core_write_data = 64'hDEAD;
        @(posedge clk); #1;
        core_write_en = 1'b0;
        total++;
        if (rf[3] !== 64'hDEAD) begin
            bad++;
            $display("FAIL done_write: x3=%h want dead", rf[3]);
        end
    endtask

    task automatic test_reset_mid();
        int nz;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1;
            in_data  = word(k);
            q.push_back('{r: 5'(k), d: word(k)});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        nz = 0;
        for (int k = 0; k < 32; k++) if (rf[k] !== 64'd0) nz++;
        total++;
        if (in_ready !== 0 || busy !== 0 || done !== 0 || nz !== 0) begin
            bad++;
            $display("FAIL reset_mid: in_ready=%0b busy=%0b done=%0b nonzero_regs=%0d want 0 0 0 0",
                     in_ready, busy, done, nz);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_load(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_verify();
        test_core_drop();
        test_reset_mid();
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d expected writes never seen, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
